// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data memory with handshake, wait-state latency, byte-enabled stores and access error flagging
module data_mem_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 64,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [DATA_W/8-1:0]  be_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 ready_o,
  output logic                 err_o,
  output logic                 busy_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_ram [DEPTH];
  logic              w_idle;
  logic              w_start;
  logic              w_enter_resp;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_word;
  logic              w_misal;
  logic              w_oor;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  // With zero wait states the access completes straight from IDLE, so the
  // live inputs stand in for the not-yet-latched request fields.
  always_comb begin
    w_idle       = r_state == S_IDLE;
    w_start      = w_idle && req_i;
    w_enter_resp = (w_start && WAIT_STATES == 0) || (r_state == S_WAIT && r_cnt == 4'd0);
    w_next       = w_idle ? (req_i ? ((WAIT_STATES == 0) ? S_RESP : S_WAIT) : S_IDLE)
                 : (r_state == S_WAIT) ? ((r_cnt == 4'd0) ? S_RESP : S_WAIT) : S_IDLE;
    w_addr       = w_idle ? addr_i  : r_addr;
    w_we         = w_idle ? we_i    : r_we;
    w_be         = w_idle ? be_i    : r_be;
    w_wdata      = w_idle ? wdata_i : r_wdata;
    w_off        = w_addr - BASE_ADDR;
    w_word       = w_off / ADDR_W'(BE_W);
    w_misal      = (BE_W > 1) && (w_addr[OFF_W-1:0] != '0);
    w_oor        = (w_addr < BASE_ADDR) || (w_word >= ADDR_W'(DEPTH));
    w_err        = w_misal || w_oor;
    w_idx        = w_word[IDX_W-1:0];
  end
  // Sequencer state and wait-state countdown
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_start ? CNT_INIT : (r_state == S_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
    end
  end
  // Capture the request so inputs are free to change once accepted
  always_ff @(posedge clk_i) begin
    if (w_start) begin
      r_addr  <= addr_i;
      r_we    <= we_i;
      r_be    <= be_i;
      r_wdata <= wdata_i;
    end
  end
  // Load data and error flag are produced on the edge entering RESP
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err   <= w_err;
      r_rdata <= w_err ? '0 : w_we ? r_rdata : r_ram[w_idx];
    end else begin
      r_err   <= 1'b0;
    end
  end
  // Byte-enabled store, committed on the edge entering RESP unless rejected
  always_ff @(posedge clk_i) begin
    if (rst_i && w_enter_resp && w_we && !w_err)
      for (int b = 0; b < BE_W; b++)
        if (w_be[b]) r_ram[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  end
  assign rdata_o = r_rdata;
  assign ready_o = r_state == S_RESP;
  assign err_o   = r_err;
  assign busy_o  = r_state != S_IDLE;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed checks of data_mem_ctrl against a word-array reference model
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        we [2];
  logic [3:0]  be [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        rdy [2];
  logic        er [2];
  logic        bsy [2];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mem_m [2][64];
  logic [31:0] last_rd [2];
  logic [31:0] g;

  always #5 clk = ~clk;

  data_mem_ctrl #(.WAIT_STATES(1), .BASE_ADDR(32'h0)) u0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wd[0]), .rdata_o(rd[0]), .ready_o(rdy[0]),
    .err_o(er[0]), .busy_o(bsy[0]));

  data_mem_ctrl #(.WAIT_STATES(0), .BASE_ADDR(32'h1000)) u1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wd[1]), .rdata_o(rd[1]), .ready_o(rdy[1]),
    .err_o(er[1]), .busy_o(bsy[1]));

  function automatic logic [31:0] base(input int s);
    return (s == 1) ? 32'h1000 : 32'h0;
  endfunction

  function automatic int ws(input int s);
    return (s == 1) ? 0 : 1;
  endfunction

  // An access is rejected when misaligned or outside the 64-word window
  function automatic bit bad(input int s, input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, base(s)});
    return (a[1:0] != 2'b00) || (off < 0) || (off >= 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic acc(input int s, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input string tag, output logic [31:0] got);
    bit e;
    int i;
    int lat;
    logic [31:0] exp_rd;
    e = bad(s, a);
    i = e ? 0 : int'((a - base(s)) >> 2);
    if (w && !e)
      for (int k = 0; k < 4; k++)
        if (b[k]) mem_m[s][i][8*k +: 8] = d[8*k +: 8];
    exp_rd = e ? 32'h0 : w ? last_rd[s] : mem_m[s][i];
    last_rd[s] = exp_rd;
    @(posedge clk); #1;
    req[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wd[s] = d;
    @(posedge clk); #1;
    req[s] = 1'b0; we[s] = 1'($urandom); be[s] = 4'($urandom); addr[s] = $urandom; wd[s] = $urandom;
    lat = 1;
    while (!rdy[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 1 + ws(s));
    chk({tag, "_err"}, 32'(er[s]), 32'(e));
    chk({tag, "_rdata"}, rd[s], exp_rd);
    chk({tag, "_busy"}, 32'(bsy[s]), 32'h1);
    got = rd[s];
    @(posedge clk); #1;
    chk({tag, "_rdy_end"}, 32'(rdy[s]), 32'h0);
    chk({tag, "_idle"}, 32'(bsy[s]), 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr(input int s);
    int r;
    r = $urandom_range(0, 9);
    return (r < 7) ? base(s) + 32'(4 * $urandom_range(0, 63))
         : (r == 7) ? base(s) + 32'($urandom_range(0, 255))
         : (r == 8) ? base(s) + 32'(256 + 4 * $urandom_range(0, 63))
         : $urandom;
  endfunction

  initial begin
    int cnt;
    int prev;
    int p;
    logic [31:0] b;
    logic [31:0] old;
    logic [31:0] d;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b1; we[s] = 1'b1; be[s] = 4'hF; addr[s] = 32'h0; wd[s] = 32'h0;
      last_rd[s] = 32'h0;
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        chk("rst_ready", 32'(rdy[s]), 32'h0);
        chk("rst_err", 32'(er[s]), 32'h0);
        chk("rst_busy", 32'(bsy[s]), 32'h0);
        chk("rst_rdata", rd[s], 32'h0);
      end
    end
    rst_n = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++)
        acc(s, 1'b1, 4'hF, base(s) + 32'(4 * i), $urandom, "init", g);

    for (int s = 0; s < 2; s++) begin
      b = base(s);
      acc(s, 1'b1, 4'hF, b + 32'h10, 32'hDEADBEEF, "st_beef", g);
      acc(s, 1'b0, 4'h0, b + 32'h10, 32'h0, "ld_beef", g);
      chk("ld_beef_val", g, 32'hDEADBEEF);
      acc(s, 1'b1, 4'hF, b + 32'h20, 32'h11223344, "st_base", g);
      acc(s, 1'b1, 4'b0101, b + 32'h20, 32'hAABBCCDD, "st_be", g);
      acc(s, 1'b0, 4'hF, b + 32'h20, 32'h0, "ld_be", g);
      chk("be_merge", g, 32'h11BB33DD);
      acc(s, 1'b1, 4'h0, b + 32'h20, 32'h55555555, "st_be0", g);
      acc(s, 1'b0, 4'h0, b + 32'h20, 32'h0, "ld_be0", g);
      chk("be0_keep", g, 32'h11BB33DD);
      acc(s, 1'b0, 4'h0, b + 32'h13, 32'h0, "ld_misal", g);
      acc(s, 1'b0, 4'h0, b + 32'h100, 32'h0, "ld_oor", g);
      acc(s, 1'b1, 4'hF, b + 32'h102, 32'hCAFEF00D, "st_bad", g);
      acc(s, 1'b0, 4'h0, b + 32'h0, 32'h0, "ld_w0", g);
      acc(s, 1'b0, 4'h0, b + 32'hFC, 32'h0, "ld_last", g);
      if (s == 1) begin
        acc(s, 1'b0, 4'h0, b - 32'h4, 32'h0, "ld_below", g);
        acc(s, 1'b0, 4'h0, 32'h0, 32'h0, "ld_zero", g);
        acc(s, 1'b1, 4'hF, 32'hFFFFFFFC, 32'h12345678, "st_wrap", g);
        acc(s, 1'b0, 4'h0, 32'hFFFFFFFC, 32'h0, "ld_wrap", g);
      end
      // Held request: one access per WAIT_STATES+2 cycles
      p = ws(s) + 2;
      @(posedge clk); #1;
      req[s] = 1'b1; we[s] = 1'b0; addr[s] = b + 32'h10;
      cnt = 0; prev = -1;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (c == 9) req[s] = 1'b0;
        if (rdy[s]) begin
          cnt++;
          if (prev < 0) chk("hold_first", 32'(c), 32'(1 + ws(s)));
          else chk("hold_gap", 32'(c - prev), 32'(p));
          chk("hold_rdata", rd[s], mem_m[s][4]);
          prev = c;
        end
      end
      chk("hold_count", 32'(cnt), 32'((9 - 1) / p + 1));
      last_rd[s] = mem_m[s][4];
    end

    // Request pulsed again during WAIT is ignored
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("pulse_busy", 32'(bsy[0]), 32'h1);
      if (c == 2) req[0] = 1'b0;
      if (rdy[0]) cnt++;
    end
    chk("pulse_count", 32'(cnt), 32'h1);

    // Reset while waiting aborts the store
    old = mem_m[0][12];
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h30; wd[0] = ~old;
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(bsy[0]), 32'h0);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rdy[0]) cnt++;
    end
    chk("abort_no_ready", 32'(cnt), 32'h0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    acc(0, 1'b0, 4'h0, 32'h30, 32'h0, "ld_abort", g);
    chk("abort_old", g, old);

    // Reset during RESP keeps the committed store
    d = $urandom;
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h1030; wd[1] = d;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("resp_rst_ready", 32'(rdy[1]), 32'h1);
    rst_n = 1'b0;
    mem_m[1][12] = d;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("resp_rst_clear", 32'(rdy[1]), 32'h0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    acc(1, 1'b0, 4'h0, 32'h1030, 32'h0, "ld_kept", g);
    chk("resp_rst_kept", g, d);

    for (int s = 0; s < 2; s++)
      for (int n = 0; n < 80; n++)
        acc(s, 1'($urandom), 4'($urandom), rnd_addr(s), $urandom, "rand", g);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
